// File: rtl/h264_pkg.sv
// Shared definitions for the H.264 quantiser/dequantiser pair:
// rescale tables, position classes and output saturation limits.
package h264_pkg;

    localparam int PW = 18;
    localparam int RW = 26;

    typedef enum logic [1:0] {
        POS_A,
        POS_B,
        POS_C
    } pos_t;

    // Packed V tables, entry k (QP%6 == k) at bits [5k+4:5k]
    localparam logic [29:0] V_A_TBL = {5'd18, 5'd16, 5'd14, 5'd13, 5'd11, 5'd10};
    localparam logic [29:0] V_B_TBL = {5'd29, 5'd25, 5'd23, 5'd20, 5'd18, 5'd16};
    localparam logic [29:0] V_C_TBL = {5'd23, 5'd20, 5'd18, 5'd16, 5'd14, 5'd13};

    localparam logic signed [RW-1:0] SAT_HI = 26'sd32767;
    localparam logic signed [RW-1:0] SAT_LO = -26'sd32767;
    localparam logic [15:0] W_SAT_POS = 16'h7FFF;
    localparam logic [15:0] W_SAT_NEG = 16'h8001;

    function automatic pos_t zig_class(input logic [3:0] zig);
        pos_t c;
        case (zig)
            4'd0, 4'd3, 4'd5, 4'd11:   c = POS_A;
            4'd4, 4'd10, 4'd12, 4'd15: c = POS_B;
            default:                   c = POS_C;
        endcase
        return c;
    endfunction

    function automatic logic [4:0] v_lookup(input pos_t cls, input logic [2:0] rem);
        logic [7:0] idx;
        logic [4:0] v;
        idx = 8'(rem) * 8'd5;
        case (cls)
            POS_A:   v = V_A_TBL[idx +: 5];
            POS_B:   v = V_B_TBL[idx +: 5];
            default: v = V_C_TBL[idx +: 5];
        endcase
        return v;
    endfunction

endpackage

// File: rtl/h264_qp_divmod6.sv
// Combinational split of QP into QP/6 (shift) and QP%6 (table index).
module h264_qp_divmod6 (
    input  logic [5:0] qp,
    output logic [3:0] quo,
    output logic [2:0] rem
);

    assign quo = 4'(qp / 6'd6);
    assign rem = 3'(qp % 6'd6);

endmodule

// File: rtl/h264dequantise.sv
// H.264 inverse quantiser: W = Z * V(QP%6,pos) * 2^(QP/6), with the
// Hadamard DC variant. Three-stage pipeline, one coefficient per clock.
module h264dequantise
    import h264_pkg::*;
#(
    parameter int ZW = 12,
    parameter int WW = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic                 DCCI,
    input  logic [5:0]           QP,
    input  logic signed [ZW-1:0] ZIN,
    output logic                 VALID,
    output logic                 DCCO,
    output logic signed [WW-1:0] WOUT
);

    logic [3:0] quo;
    logic [2:0] rem;
    pos_t       cls;

    logic [3:0]           zig_q, zig_d;
    logic                 en1_q, en1_d;
    logic                 dc1_q, dc1_d;
    logic signed [ZW-1:0] z1_q, z1_d;
    logic [4:0]           v1_q, v1_d;
    logic [3:0]           sh1_q, sh1_d;
    logic                 en2_q, en2_d;
    logic                 dc2_q, dc2_d;
    logic signed [PW-1:0] p2_q, p2_d;
    logic [3:0]           sh2_q, sh2_d;
    logic                 valid_q, valid_d;
    logic                 dcco_q, dcco_d;
    logic [WW-1:0]        wout_q, wout_d;

    logic signed [PW-1:0] z_ext, v_ext;
    logic signed [RW-1:0] p_ext, r;
    logic [WW-1:0]        w_sat;

    h264_qp_divmod6 u_divmod (
        .qp  (QP),
        .quo (quo),
        .rem (rem)
    );

    // Stage 1: position class, table lookup, block position tracking
    always_comb begin
        zig_d = (!ENABLE || DCCI) ? 4'hF : zig_q - 4'd1;
        cls   = DCCI ? POS_A : zig_class(zig_q);
        en1_d = ENABLE;
        dc1_d = ENABLE & DCCI;
        z1_d  = z1_q;
        v1_d  = v1_q;
        sh1_d = sh1_q;
        if (ENABLE) begin
            z1_d  = ZIN;
            v1_d  = v_lookup(cls, rem);
            sh1_d = quo;
        end
    end

    // Stage 2: exact 18-bit signed product
    always_comb begin
        z_ext = {{(PW - ZW){z1_q[ZW-1]}}, z1_q};
        v_ext = {{(PW - 5){1'b0}}, v1_q};
        en2_d = en1_q;
        dc2_d = en1_q & dc1_q;
        p2_d  = p2_q;
        sh2_d = sh2_q;
        if (en1_q) begin
            p2_d  = z_ext * v_ext;
            sh2_d = sh1_q;
        end
    end

    // Stage 3: scale, DC rounding for small shifts, symmetric saturation
    always_comb begin
        p_ext = {{(RW - PW){p2_q[PW-1]}}, p2_q};
        if (!dc2_q) begin
            r = p_ext <<< sh2_q;
        end else if (sh2_q >= 4'd2) begin
            r = p_ext <<< (sh2_q - 4'd2);
        end else if (sh2_q == 4'd0) begin
            r = (p_ext + 26'sd2) >>> 2;
        end else begin
            r = (p_ext + 26'sd1) >>> 1;
        end
        if (r > SAT_HI) begin
            w_sat = W_SAT_POS;
        end else if (r < SAT_LO) begin
            w_sat = W_SAT_NEG;
        end else begin
            w_sat = r[WW-1:0];
        end
        valid_d = en2_q;
        dcco_d  = en2_q & dc2_q;
        wout_d  = en2_q ? w_sat : wout_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            zig_q   <= 4'hF;
            en1_q   <= 1'b0;
            dc1_q   <= 1'b0;
            z1_q    <= '0;
            v1_q    <= '0;
            sh1_q   <= '0;
            en2_q   <= 1'b0;
            dc2_q   <= 1'b0;
            p2_q    <= '0;
            sh2_q   <= '0;
            valid_q <= 1'b0;
            dcco_q  <= 1'b0;
            wout_q  <= '0;
        end else begin
            zig_q   <= zig_d;
            en1_q   <= en1_d;
            dc1_q   <= dc1_d;
            z1_q    <= z1_d;
            v1_q    <= v1_d;
            sh1_q   <= sh1_d;
            en2_q   <= en2_d;
            dc2_q   <= dc2_d;
            p2_q    <= p2_d;
            sh2_q   <= sh2_d;
            valid_q <= valid_d;
            dcco_q  <= dcco_d;
            wout_q  <= wout_d;
        end
    end

    assign VALID = valid_q;
    assign DCCO  = dcco_q;
    assign WOUT  = wout_q;

endmodule

// File: tb/tb_h264dequantise.sv
// Scoreboard bench for h264dequantise: randomized and directed stimulus
// checked against an arithmetic reference of the rescale rules.
module tb_h264dequantise;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        DCCI;
    logic [5:0]  QP;
    logic signed [11:0] ZIN;
    logic        VALID;
    logic        DCCO;
    logic signed [15:0] WOUT;

    h264dequantise #(.ZW(12), .WW(16)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENABLE (ENABLE),
        .DCCI   (DCCI),
        .QP     (QP),
        .ZIN    (ZIN),
        .VALID  (VALID),
        .DCCO   (DCCO),
        .WOUT   (WOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] w;
        logic        dc;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          run = 0;
    logic [15:0] last_w = 16'h0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at cycle %0d",
                     nm, act, act, req, req, cyc);
        end
    endtask

    function automatic logic [15:0] model(input bit dc, input int qp,
                                          input int z, input int zig);
        int va[6] = '{10, 11, 13, 14, 16, 18};
        int vb[6] = '{16, 18, 20, 23, 25, 29};
        int vc[6] = '{13, 14, 16, 18, 20, 23};
        int m, sh, v, d;
        longint p, n, r;
        logic [63:0] rv;
        m  = qp % 6;
        sh = qp / 6;
        if (dc || zig inside {0, 3, 5, 11}) v = va[m];
        else if (zig inside {4, 10, 12, 15}) v = vb[m];
        else v = vc[m];
        p = longint'(z) * v;
        if (!dc) begin
            r = p * (longint'(1) << sh);
        end else if (sh >= 2) begin
            r = p * (longint'(1) << (sh - 2));
        end else begin
            d = 1 << (2 - sh);
            n = p + (1 << (1 - sh));
            r = (n >= 0) ? n / d : -((-n + d - 1) / d);
        end
        if (r > 32767) r = 32767;
        if (r < -32767) r = -32767;
        rv = r;
        return rv[15:0];
    endfunction

    task automatic drive(input bit en, input bit dc, input int qp, input int z);
        exp_t e;
        int   zig;
        ENABLE = en;
        DCCI   = dc;
        QP     = 6'(qp);
        ZIN    = 12'(z);
        if (en) begin
            zig   = dc ? 15 : 15 - (run % 16);
            e.w   = model(dc, qp, z, zig);
            e.dc  = dc;
            e.cyc = cyc + 3;
            sbq.push_back(e);
        end
        if (en && !dc) run++;
        else run = 0;
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RESET) begin
            if (VALID) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stale: VALID with nothing expected, WOUT=0x%h", WOUT);
                end else begin
                    e = sbq.pop_front();
                    chk("wout", int'(WOUT), int'($signed(e.w)));
                    chk("dcco", int'(DCCO), int'(e.dc));
                    chk("latency_cycle", cyc, e.cyc);
                    last_w = e.w;
                end
            end else begin
                chk("wout_hold", int'(WOUT), int'($signed(last_w)));
                chk("dcco_idle", int'(DCCO), 0);
            end
        end
    end

    initial begin
        RESET  = 1'b1;
        ENABLE = 1'b0;
        DCCI   = 1'b0;
        QP     = 6'd0;
        ZIN    = 12'sd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_valid", int'(VALID), 0);
        chk("reset_dcco", int'(DCCO), 0);
        chk("reset_wout", int'(WOUT), 0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 16; i++) drive(1, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0);

        drive(1, 0, 28, -3);
        repeat (2) drive(0, 0, 0, 0);

        drive(1, 1, 6, 5);
        drive(1, 1, 18, 5);
        drive(1, 1, 0, -1);
        repeat (2) drive(0, 0, 0, 0);

        for (int i = 0; i < 15; i++) drive(1, 0, $urandom_range(51), 0);
        drive(1, 0, 51, 2047);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 15; i++) drive(1, 0, $urandom_range(51), 0);
        drive(1, 0, 51, -2048);
        repeat (3) drive(0, 0, 0, 0);

        for (int i = 0; i < 6; i++) drive(1, 0, $urandom_range(51), $urandom_range(4095) - 2048);
        ENABLE = 1'b1;
        ZIN    = 12'sd100;
        RESET  = 1'b1;
        sbq.delete();
        last_w = 16'h0;
        run    = 0;
        #1;
        chk("midreset_valid", int'(VALID), 0);
        chk("midreset_wout", int'(WOUT), 0);
        chk("midreset_dcco", int'(DCCO), 0);
        @(posedge CLK);
        #1;
        ENABLE = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        drive(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) drive(1, 0, $urandom_range(51), $urandom_range(4095) - 2048);
        repeat (3) drive(0, 0, 0, 0);

        for (int i = 0; i < 5; i++) drive(1, 0, 20, 7);
        repeat (2) drive(0, 0, 0, 0);
        for (int i = 0; i < 11; i++) drive(1, 0, 20, 7);
        repeat (3) drive(0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(9) < 8, $urandom_range(9) == 0,
                  $urandom_range(51), $urandom_range(4095) - 2048);
        end

        repeat (8) drive(0, 0, 0, 0);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
